// File: rtl/bus_arbiter_if.sv
// CPU, DMA and shared-bus signal bundle for the bus arbiter.
// The arbiter takes the slave view; the requesters and memory take the master view.
interface bus_arbiter_if;
    logic        cpu_req;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;

    logic        dma_req;
    logic        dma_wr;
    logic        dma_last;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata,
        input  dma_req, dma_wr, dma_last, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output bus_rd, bus_wr, bus_addr, bus_wdata,
        input  bus_rdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata,
        output dma_req, dma_wr, dma_last, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  bus_rd, bus_wr, bus_addr, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port shared data bus arbiter: the CPU normally owns the bus, while the DMA
// port gets bursts when the CPU is idle or has starved it for STARVE_LIMIT cycles.
module bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input logic         clk,
    input logic         reset,
    bus_arbiter_if.slave bus
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);
    localparam logic [BW-1:0] BEAT_MAX   = BW'(MAX_BURST);
    localparam logic [BW-1:0] BEAT_ONE   = BW'(1);

    typedef enum logic {
        CPU_OWN,
        DMA_BURST
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic          cpu_turn, cpu_turn_nxt;
    logic          cpu_gnt, dma_gnt_raw;
    logic          cpu_sel, dma_sel;
    logic [BW-1:0] beat_inc;

    assign beat_inc = beat_cnt + BEAT_ONE;

    // cpu_turn reserves the cycle after a burst was cut short at MAX_BURST for the CPU
    always_comb begin
        state_nxt    = state;
        starve_nxt   = starve_cnt;
        beat_nxt     = beat_cnt;
        cpu_turn_nxt = 1'b0;
        cpu_gnt      = 1'b0;
        dma_gnt_raw  = 1'b0;
        case (state)
            CPU_OWN: begin
                beat_nxt = '0;
                if (bus.cpu_req && (!bus.dma_req || cpu_turn || starve_cnt != STARVE_MAX)) begin
                    cpu_gnt = 1'b1;
                    if (!bus.dma_req)
                        starve_nxt = '0;
                    else if (starve_cnt != STARVE_MAX)
                        starve_nxt = starve_cnt + STARVE_ONE;
                end else if (bus.dma_req) begin
                    dma_gnt_raw = 1'b1;
                    beat_nxt    = BEAT_ONE;
                    if (bus.cpu_req)
                        starve_nxt = '0;
                    if (!bus.dma_last && BEAT_ONE != BEAT_MAX) begin
                        state_nxt = DMA_BURST;
                    end else if (!bus.dma_last) begin
                        beat_nxt     = '0;
                        starve_nxt   = '0;
                        cpu_turn_nxt = 1'b1;
                    end
                end
            end
            DMA_BURST: begin
                state_nxt = CPU_OWN;
                beat_nxt  = '0;
                if (bus.dma_req) begin
                    dma_gnt_raw = 1'b1;
                    if (beat_cnt != BEAT_MAX && beat_inc == BEAT_MAX) begin
                        starve_nxt   = '0;
                        cpu_turn_nxt = 1'b1;
                    end else if (!bus.dma_last && beat_cnt != BEAT_MAX) begin
                        state_nxt = DMA_BURST;
                        beat_nxt  = beat_inc;
                    end
                end
            end
            default: state_nxt = CPU_OWN;
        endcase
    end

    // Grants are masked by reset so the bus goes quiet the instant reset asserts
    assign cpu_sel = cpu_gnt && reset;
    assign dma_sel = dma_gnt_raw && reset;

    assign bus.dma_gnt   = dma_sel;
    assign bus.cpu_stall = reset && bus.cpu_req && !cpu_gnt;
    assign bus.cpu_rdata = (cpu_sel && !bus.cpu_wr) ? bus.bus_rdata : 32'h0;
    assign bus.bus_rd    = (cpu_sel && !bus.cpu_wr) || (dma_sel && !bus.dma_wr);
    assign bus.bus_wr    = (cpu_sel && bus.cpu_wr) || (dma_sel && bus.dma_wr);
    assign bus.bus_addr  = cpu_sel ? bus.cpu_addr  : (dma_sel ? bus.dma_addr  : 32'h0);
    assign bus.bus_wdata = cpu_sel ? bus.cpu_wdata : (dma_sel ? bus.dma_wdata : 32'h0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CPU_OWN;
            starve_cnt <= '0;
            beat_cnt   <= '0;
            cpu_turn   <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            beat_cnt   <= beat_nxt;
            cpu_turn   <= cpu_turn_nxt;
        end
    end

    // DMA read data is captured at the grant edge and returned one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.dma_rvalid <= 1'b0;
            bus.dma_rdata  <= 32'h0;
        end else begin
            bus.dma_rvalid <= dma_sel && !bus.dma_wr;
            if (dma_sel && !bus.dma_wr)
                bus.dma_rdata <= bus.bus_rdata;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: grant expectations come from per-cycle patterns,
// DMA read data is queued at grant time and popped when dma_rvalid is due.
module tb_bus_arbiter;

    localparam int G_NONE = 0;
    localparam int G_CPU  = 1;
    localparam int G_DMA  = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    logic [31:0] last_rdata;
    logic [31:0] rd_q[$];

    bus_arbiter_if bif ();

    bus_arbiter #(
        .STARVE_LIMIT(4),
        .MAX_BURST   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic checkRvalid();
        logic [31:0] exp;
        if (rd_q.size() > 0) begin
            exp = rd_q.pop_front();
            checkOutput("dma_rvalid", 32'(bif.dma_rvalid), 32'd1);
            last_rdata = exp;
        end else begin
            checkOutput("dma_rvalid", 32'(bif.dma_rvalid), 32'd0);
        end
        checkOutput("dma_rdata", bif.dma_rdata, last_rdata);
    endtask

    task automatic setIdle();
        bif.cpu_req   = 1'b0;
        bif.cpu_wr    = 1'b0;
        bif.cpu_addr  = 32'h0;
        bif.cpu_wdata = 32'h0;
        bif.dma_req   = 1'b0;
        bif.dma_wr    = 1'b0;
        bif.dma_last  = 1'b0;
        bif.dma_addr  = 32'h0;
        bif.dma_wdata = 32'h0;
        bif.bus_rdata = 32'h0;
    endtask

    task automatic applyStimulus(input logic c_req, input logic c_wr,
                                 input logic [31:0] c_addr, input logic [31:0] c_wdata,
                                 input logic d_req, input logic d_wr, input logic d_last,
                                 input logic [31:0] d_addr, input logic [31:0] d_wdata,
                                 input logic [31:0] rdata, input int grant);
        logic ec;
        logic ed;
        @(negedge clk);
        bif.cpu_req   = c_req;
        bif.cpu_wr    = c_wr;
        bif.cpu_addr  = c_addr;
        bif.cpu_wdata = c_wdata;
        bif.dma_req   = d_req;
        bif.dma_wr    = d_wr;
        bif.dma_last  = d_last;
        bif.dma_addr  = d_addr;
        bif.dma_wdata = d_wdata;
        bif.bus_rdata = rdata;
        cyc++;
        #3;
        checkRvalid();
        ec = (grant == G_CPU);
        ed = (grant == G_DMA);
        checkOutput("dma_gnt",   32'(bif.dma_gnt),   32'(ed));
        checkOutput("cpu_stall", 32'(bif.cpu_stall), 32'(c_req && !ec));
        checkOutput("bus_rd",    32'(bif.bus_rd),    32'((ec && !c_wr) || (ed && !d_wr)));
        checkOutput("bus_wr",    32'(bif.bus_wr),    32'((ec && c_wr) || (ed && d_wr)));
        checkOutput("bus_addr",  bif.bus_addr,  ec ? c_addr  : (ed ? d_addr  : 32'h0));
        checkOutput("bus_wdata", bif.bus_wdata, ec ? c_wdata : (ed ? d_wdata : 32'h0));
        checkOutput("cpu_rdata", bif.cpu_rdata, (ec && !c_wr) ? rdata : 32'h0);
        if (ed && !d_wr)
            rd_q.push_back(rdata);
    endtask

    // Both ports request every cycle; 'C'/'D' in pat is the expected winner
    task automatic runContest(input string pat, input logic d_wr, input int last_beat);
        int   beats;
        logic d_last;
        int   g;
        beats = 0;
        for (int i = 0; i < pat.len(); i++) begin
            d_last = (last_beat < 0) || (beats == last_beat - 1);
            g = (pat[i] == "D") ? G_DMA : G_CPU;
            applyStimulus(1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h0,
                          1'b1, d_wr, d_last, 32'h300 + 32'(beats * 4),
                          32'hC0DE_0000 + 32'(beats), 32'hA500_0000 + 32'(cyc), g);
            if (g == G_DMA)
                beats++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        last_rdata = 32'h0;
        reset = 1'b0;
        setIdle();

        // Requests under reset must not reach the bus
        repeat (2) @(negedge clk);
        bif.cpu_req = 1'b1;
        bif.dma_req = 1'b1;
        #3;
        checkOutput("rst_dma_gnt",   32'(bif.dma_gnt),   32'd0);
        checkOutput("rst_cpu_stall", 32'(bif.cpu_stall), 32'd0);
        checkOutput("rst_bus_rd",    32'(bif.bus_rd),    32'd0);
        checkOutput("rst_bus_wr",    32'(bif.bus_wr),    32'd0);
        checkOutput("rst_rvalid",    32'(bif.dma_rvalid), 32'd0);
        checkOutput("rst_rdata",     bif.dma_rdata, 32'h0);
        @(negedge clk);
        setIdle();
        reset = 1'b1;

        // Idle: no grants, counters stay at zero
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, G_NONE);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, G_NONE);
        checkOutput("idle_starve", 32'(dut.starve_cnt), 32'd0);
        checkOutput("idle_beat",   32'(dut.beat_cnt),   32'd0);

        // CPU-only read and write
        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, G_CPU);
        applyStimulus(1, 1, 32'h14, 32'h5555_AAAA, 0, 0, 0, 0, 0, 32'h0BAD_0BAD, G_CPU);

        // Continuous contention with single-beat DMA reads
        runContest("CCCCDCCCCD", 1'b0, -1);

        // Three-beat DMA read burst while the CPU is idle
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h100, 0, 32'h1111_0100, G_DMA);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h104, 0, 32'h2222_0104, G_DMA);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'h108, 0, 32'h3333_0108, G_DMA);
        applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 32'h4444_0020, G_CPU);

        // Long DMA write stream against a busy CPU: burst capped at MAX_BURST
        runContest("CCCCDDDDDDDDCCCCDDDD", 1'b1, 12);

        // DMA dropping its request mid-burst hands the bus back with a dead cycle
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h500, 0, 32'h5555_0500, G_DMA);
        applyStimulus(1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 32'h6666_0030, G_NONE);
        applyStimulus(1, 0, 32'h34, 0, 0, 0, 0, 0, 0, 32'h7777_0034, G_CPU);

        // Reset on the second beat of a DMA write burst
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 32'h400, 32'hAAAA_0000, 0, G_DMA);
        @(negedge clk);
        bif.dma_req   = 1'b1;
        bif.dma_wr    = 1'b1;
        bif.dma_addr  = 32'h404;
        bif.dma_wdata = 32'hAAAA_0001;
        #1;
        reset = 1'b0;
        #2;
        checkOutput("mid_rst_dma_gnt", 32'(bif.dma_gnt),    32'd0);
        checkOutput("mid_rst_bus_wr",  32'(bif.bus_wr),     32'd0);
        checkOutput("mid_rst_rvalid",  32'(bif.dma_rvalid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_bus_wr2", 32'(bif.bus_wr),     32'd0);
        checkOutput("mid_rst_starve",  32'(dut.starve_cnt), 32'd0);
        checkOutput("mid_rst_beat",    32'(dut.beat_cnt),   32'd0);
        @(negedge clk);
        setIdle();
        rd_q.delete();
        last_rdata = 32'h0;
        reset = 1'b1;

        // After release arbitration restarts from CPU_OWN with a clear starvation count
        applyStimulus(1, 0, 32'h40, 0, 1, 0, 1, 32'h600, 0, 32'h8888_0040, G_CPU);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, G_NONE);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, G_NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
